// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl
// Write-domain pointer and full-flag controller for a dual-clock FIFO.
// Keeps the write pointer in binary (memory address) and Gray (crossing to
// the read domain) form, and derives full / almost-full / occupancy /
// overflow status against the read pointer already synchronized into clk.
//
// Ports
//   clk           write-domain clock
//   rst_n         synchronous active-low reset
//   winc          write request from the producer
//   wq2_rptr      Gray read pointer, synchronized into clk
//   waddr         memory write address (registered)
//   wptr          Gray write pointer to the write-to-read synchronizer
//   wfull         FIFO full
//   walmost_full  occupancy >= AFULL_THRESH
//   wcount        occupancy estimate, 0..2^ADDR_WIDTH
//   woverflow     sticky: write attempted while full
module wptr_full_ctrl #(
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   wptr,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [ADDR_WIDTH:0]   wcount,
   output logic                  woverflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] THRESH = PW'(AFULL_THRESH);

   logic [ADDR_WIDTH:0] wbin_q, wbin_d;
   logic [ADDR_WIDTH:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH:0] wcount_q, wcount_d;
   logic                wfull_q, wfull_d;
   logic                wafull_q, wafull_d;
   logic                wovf_q, wovf_d;

   logic                push;
   logic [ADDR_WIDTH:0] rbin_sync;
   logic [ADDR_WIDTH:0] full_cmp;

   assign push = winc & ~wfull_q;

   // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rbin_sync = '0;
      rbin_sync[ADDR_WIDTH] = wq2_rptr[ADDR_WIDTH];
      for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
         rbin_sync[i] = rbin_sync[i+1] ^ wq2_rptr[i];
      end
   end

   // Full when the write pointer is exactly one lap ahead: in Gray form that
   // means the top two bits are inverted and the rest match.
   assign full_cmp = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};

   always_comb begin
      wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, push};
      wptr_d   = (wbin_d >> 1) ^ wbin_d;
      wcount_d = wbin_d - rbin_sync;
      wfull_d  = (wptr_d == full_cmp);
      wafull_d = (wcount_d >= THRESH);
      wovf_d   = wovf_q | (winc & wfull_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wbin_q   <= '0;
         wptr_q   <= '0;
         wcount_q <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wovf_q   <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wptr_q   <= wptr_d;
         wcount_q <= wcount_d;
         wfull_q  <= wfull_d;
         wafull_q <= wafull_d;
         wovf_q   <= wovf_d;
      end
   end

   assign waddr        = wbin_q[ADDR_WIDTH-1:0];
   assign wptr         = wptr_q;
   assign wfull        = wfull_q;
   assign walmost_full = wafull_q;
   assign wcount       = wcount_q;
   assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl (ADDR_WIDTH=4, AFULL_THRESH=12).
module tb_wptr_full_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       winc;
   logic [4:0] wq2_rptr;
   logic [3:0] waddr;
   logic [4:0] wptr;
   logic       wfull;
   logic       walmost_full;
   logic [4:0] wcount;
   logic       woverflow;

   int checks = 0;
   int errors = 0;

   wptr_full_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .winc         (winc),
      .wq2_rptr     (wq2_rptr),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wcount       (wcount),
      .woverflow    (woverflow)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] gray(input int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle to the falling edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".waddr"}, 32'(waddr), 0);
      chk({tag, ".wptr"}, 32'(wptr), 0);
      chk({tag, ".wfull"}, 32'(wfull), 0);
      chk({tag, ".wafull"}, 32'(walmost_full), 0);
      chk({tag, ".wcount"}, 32'(wcount), 0);
      chk({tag, ".wovf"}, 32'(woverflow), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; winc = 1'b0; wq2_rptr = '0;
      step();
      rst_n = 1'b1;
   endtask

   logic [4:0] prev_wptr;
   logic [4:0] diff;

   initial begin
      rst_n = 1'b0; winc = 1'b1; wq2_rptr = 5'b10110;
      @(negedge clk);

      // Reset held with activity on the inputs
      for (int i = 0; i < 3; i++) begin
         step();
         chk_zero("reset_hold");
      end
      rst_n = 1'b1; winc = 1'b0; wq2_rptr = 5'b00000;
      step();
      chk_zero("reset_release");

      // Fill
      winc = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("fill.waddr_pre", 32'(waddr), 32'(i));
         step();
         chk("fill.waddr", 32'(waddr), 32'((i + 1) % 16));
         chk("fill.wptr", 32'(wptr), 32'(gray(i + 1)));
         chk("fill.wcount", 32'(wcount), 32'(i + 1));
         chk("fill.wfull", 32'(wfull), (i == 15) ? 1 : 0);
         chk("fill.wafull", 32'(walmost_full), (i + 1 >= 12) ? 1 : 0);
         chk("fill.wovf", 32'(woverflow), 0);
      end
      chk("fill.wptr_end", 32'(wptr), 32'h18);

      // Overflow
      for (int i = 0; i < 2; i++) begin
         step();
         chk("ovf.wptr", 32'(wptr), 32'h18);
         chk("ovf.waddr", 32'(waddr), 0);
         chk("ovf.wfull", 32'(wfull), 1);
         chk("ovf.wcount", 32'(wcount), 16);
         chk("ovf.wovf", 32'(woverflow), 1);
      end
      winc = 1'b0;
      step();
      chk("ovf.sticky", 32'(woverflow), 1);
      rst_n = 1'b0;
      step();
      chk_zero("ovf_reset");
      rst_n = 1'b1;
      step();
      chk_zero("ovf_reset_after");

      // Release
      winc = 1'b1;
      repeat (16) step();
      chk("rel.full_before", 32'(wfull), 1);
      winc = 1'b0; wq2_rptr = 5'b00001;
      step();
      chk("rel.wfull", 32'(wfull), 0);
      chk("rel.wcount", 32'(wcount), 15);
      chk("rel.wafull", 32'(walmost_full), 1);
      chk("rel.waddr_pre", 32'(waddr), 0);
      winc = 1'b1;
      step();
      chk("rel.waddr", 32'(waddr), 1);
      chk("rel.wptr", 32'(wptr), 32'(gray(17)));
      chk("rel.wcount2", 32'(wcount), 16);
      chk("rel.wfull2", 32'(wfull), 1);
      chk("rel.wovf", 32'(woverflow), 0);

      // Almost-full boundary
      do_reset();
      winc = 1'b1;
      repeat (11) step();
      chk("af.wcount11", 32'(wcount), 11);
      chk("af.wafull11", 32'(walmost_full), 0);
      step();
      chk("af.wcount12", 32'(wcount), 12);
      chk("af.wafull12", 32'(walmost_full), 1);
      winc = 1'b0; wq2_rptr = gray(1);
      step();
      chk("af.wcount_rd", 32'(wcount), 11);
      chk("af.wafull_rd", 32'(walmost_full), 0);

      // Wrap with simultaneous read advance at occupancy 8
      do_reset();
      winc = 1'b1;
      repeat (8) step();
      chk("wrap.wcount_start", 32'(wcount), 8);
      for (int k = 0; k < 40; k++) begin
         prev_wptr = wptr;
         wq2_rptr = gray(k + 1);
         step();
         diff = prev_wptr ^ wptr;
         chk("wrap.wcount", 32'(wcount), 8);
         chk("wrap.wfull", 32'(wfull), 0);
         chk("wrap.wovf", 32'(woverflow), 0);
         chk("wrap.waddr", 32'(waddr), 32'((9 + k) % 16));
         chk("wrap.wptr", 32'(wptr), 32'(gray((9 + k) % 32)));
         chk("wrap.gray_step", 32'($countones(diff)), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
